// File: rtl/agni_sm_pkg.sv
// rtl/agni_sm_pkg.sv - shared op-class and warp-state types for the SM warp tracking logic
package agni_sm_pkg;

  typedef enum logic [2:0] {
    OP_ALU   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_FENCE = 3'd2,
    OP_BAR   = 3'd3,
    OP_DIV   = 3'd4,
    OP_EXIT  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    WS_IDLE  = 2'd0,
    WS_RUN   = 2'd1,
    WS_DRAIN = 2'd2
  } warp_st_e;

endpackage

// File: rtl/warp_ld_counter.sv
// rtl/warp_ld_counter.sv - per-warp outstanding-load counter with saturation and underflow detection
module warp_ld_counter #(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic cnt_zero,
  output logic cnt_one,
  output logic cnt_full,
  output logic err
);

  logic [CW-1:0] cnt_q;
  logic          inc_ok;
  logic          dec_ok;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_one  = (cnt_q == CW'(1));
  assign cnt_full = (cnt_q == CW'(MAX_OUTSTANDING));

  // An illegal half of a simultaneous inc/dec is dropped; the legal half still applies.
  assign inc_ok = inc & ~cnt_full;
  assign dec_ok = dec & ~cnt_zero;
  assign err    = (inc & cnt_full) | (dec & cnt_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/warp_state_tracker.sv
// rtl/warp_state_tracker.sv - per-SM warp lifecycle FSMs, stall/barrier/diverge masks and free arbiter
module warp_state_tracker
  import agni_sm_pkg::*;
#(
  parameter  int NUM_WARPS       = 32,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int WID             = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_valid,
  input  logic [WID-1:0]       launch_warp_id,
  input  logic                 issue_valid,
  input  logic [WID-1:0]       issue_warp_id,
  input  op_e                  issue_op,
  input  logic                 mem_resp_valid,
  input  logic [WID-1:0]       mem_resp_warp_id,
  input  logic                 reconv_valid,
  input  logic [WID-1:0]       reconv_warp_id,
  output logic [NUM_WARPS-1:0] active_mask,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic [NUM_WARPS-1:0] barrier_mask,
  output logic [NUM_WARPS-1:0] diverge_mask,
  output logic                 barrier_release,
  output logic                 warp_free,
  output logic [WID-1:0]       free_warp_id,
  output logic                 err_sticky
);

  warp_st_e             st_q [NUM_WARPS];
  warp_st_e             st_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] fence_q, fence_d, bar_q, bar_d, div_q, div_d;
  logic [NUM_WARPS-1:0] pend_q, pend_d, cand, free_set;
  logic [NUM_WARPS-1:0] inc, dec, cnt_zero, cnt_one, cnt_full, cnt_err;
  logic [NUM_WARPS-1:0] active_vec, blocked;
  logic                 release_now, err_d, free_any;
  logic [WID-1:0]       free_idx;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_cnt
    warp_ld_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[g]),
      .dec      (dec[g]),
      .cnt_zero (cnt_zero[g]),
      .cnt_one  (cnt_one[g]),
      .cnt_full (cnt_full[g]),
      .err      (cnt_err[g])
    );
  end

  always_comb begin
    active_vec = '0;
    for (int w = 0; w < NUM_WARPS; w++) active_vec[w] = (st_q[w] == WS_RUN);
  end

  assign blocked     = cnt_full | fence_q | bar_q | div_q;
  // Non-running warps count as arrived so an exiting warp can complete a barrier.
  assign release_now = (bar_q != '0) && (&(bar_q | ~active_vec));

  always_comb begin
    err_d    = 1'b0;
    inc      = '0;
    dec      = '0;
    free_set = '0;
    fence_d  = fence_q;
    bar_d    = release_now ? '0 : bar_q;
    div_d    = div_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      st_d[w] = st_q[w];
      if (launch_valid && launch_warp_id == WID'(w) && st_q[w] == WS_IDLE) begin
        st_d[w]    = WS_RUN;
        fence_d[w] = 1'b0;
        bar_d[w]   = 1'b0;
        div_d[w]   = 1'b0;
      end else begin
        if (launch_valid && launch_warp_id == WID'(w)) err_d = 1'b1;
        if (mem_resp_valid && mem_resp_warp_id == WID'(w)) dec[w] = 1'b1;
        if (issue_valid && issue_warp_id == WID'(w)) begin
          if (st_q[w] != WS_RUN || blocked[w]) begin
            err_d = 1'b1;
          end else begin
            case (issue_op)
              OP_LOAD:  inc[w] = 1'b1;
              OP_FENCE: if (!cnt_zero[w]) fence_d[w] = 1'b1;
              OP_BAR:   bar_d[w] = 1'b1;
              OP_DIV:   div_d[w] = 1'b1;
              OP_EXIT: begin
                if (cnt_zero[w] || (dec[w] && cnt_one[w])) begin
                  st_d[w]     = WS_IDLE;
                  free_set[w] = 1'b1;
                end else begin
                  st_d[w] = WS_DRAIN;
                end
              end
              default: ;
            endcase
          end
        end
        if (reconv_valid && reconv_warp_id == WID'(w)) div_d[w] = 1'b0;
        if (dec[w] && cnt_one[w] && !inc[w]) fence_d[w] = 1'b0;
        if (st_q[w] == WS_DRAIN && (cnt_zero[w] || (dec[w] && cnt_one[w]))) begin
          st_d[w]     = WS_IDLE;
          free_set[w] = 1'b1;
        end
        if (st_d[w] != WS_RUN) begin
          fence_d[w] = 1'b0;
          bar_d[w]   = 1'b0;
          div_d[w]   = 1'b0;
        end
      end
    end
  end

  // Lowest pending ID is freed first; the rest wait in the pending bitmap.
  always_comb begin
    cand     = pend_q | free_set;
    free_any = 1'b0;
    free_idx = '0;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (cand[w]) begin
        free_any = 1'b1;
        free_idx = WID'(w);
      end
    end
    pend_d = cand;
    if (free_any) pend_d[free_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) st_q[w] <= WS_IDLE;
      fence_q         <= '0;
      bar_q           <= '0;
      div_q           <= '0;
      pend_q          <= '0;
      barrier_release <= 1'b0;
      warp_free       <= 1'b0;
      free_warp_id    <= '0;
      err_sticky      <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) st_q[w] <= st_d[w];
      fence_q         <= fence_d;
      bar_q           <= bar_d;
      div_q           <= div_d;
      pend_q          <= pend_d;
      barrier_release <= release_now;
      warp_free       <= free_any;
      if (free_any) free_warp_id <= free_idx;
      err_sticky      <= err_sticky | err_d | (|cnt_err);
    end
  end

  assign active_mask  = active_vec;
  assign stall_mask   = cnt_full | fence_q;
  assign barrier_mask = bar_q;
  assign diverge_mask = div_q;

endmodule
